// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU engine that owns the HI/LO registers.
// Each RUN cycle does one shift-add or restoring-subtract step on magnitudes; SIGN applies the fix-up.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]      CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      CNT_LAST = {CW{1'b1}};
  localparam logic [WIDTH-1:0]   W_ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   W_ONES   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] D_ZERO   = {(2*WIDTH){1'b0}};
  localparam logic [2*WIDTH-1:0] D_ONE    = {{(2*WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SIGN = 2'd2
  } state_e;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
    logic [WIDTH-1:0] r;
    if (en) r = ~v + W_ONE;
    else    r = v;
    return r;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg2_if(input logic [2*WIDTH-1:0] v, input logic en);
    logic [2*WIDTH-1:0] r;
    if (en) r = ~v + D_ONE;
    else    r = v;
    return r;
  endfunction

  state_e             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Operand magnitudes at issue; only the signed ops (op[0]) look at the sign bits.
  logic             sgn_a_s, sgn_b_s;
  logic [WIDTH-1:0] mag_a_s, mag_b_s;
  assign sgn_a_s = op[0] & busA[WIDTH-1];
  assign sgn_b_s = op[0] & busB[WIDTH-1];
  assign mag_a_s = neg_if(busA, sgn_a_s);
  assign mag_b_s = neg_if(busB, sgn_b_s);

  // Multiply step: acc = {partial product, remaining multiplier bits}, shifted right each cycle.
  logic [WIDTH-1:0]   addend_s;
  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] mul_step_s;
  assign addend_s   = acc_q[0] ? opnd_q : W_ZERO;
  assign sum_s      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend_s};
  assign mul_step_s = {sum_s, acc_q[WIDTH-1:1]};

  // Divide step: acc = {partial remainder, dividend/quotient bits}, shifted left each cycle.
  logic [WIDTH:0]     shift_s;
  logic               ge_s;
  logic [WIDTH-1:0]   rem_next_s;
  logic [2*WIDTH-1:0] div_step_s;
  assign shift_s    = acc_q[2*WIDTH-1:WIDTH-1];
  assign ge_s       = (shift_s >= {1'b0, opnd_q});
  assign rem_next_s = ge_s ? (shift_s[WIDTH-1:0] - opnd_q) : shift_s[WIDTH-1:0];
  assign div_step_s = {rem_next_s, acc_q[WIDTH-2:0], ge_s};

  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   quo_fix_s, rem_fix_s;
  assign prod_fix_s = neg2_if(acc_q, neg_res_q);
  assign quo_fix_s  = neg_if(acc_q[WIDTH-1:0], neg_res_q);
  assign rem_fix_s  = neg_if(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);

  // Next-state and datapath update for the IDLE/RUN/SIGN sequencer.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    is_div_d  = is_div_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    dvd_d     = dvd_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_div_d  = op[1];
          dvd_d     = busA;
          neg_res_d = sgn_a_s ^ sgn_b_s;
          neg_rem_d = sgn_a_s;
          count_d   = CNT_ZERO;
          state_d   = S_RUN;
          if (op[1]) begin
            opnd_d = mag_b_s;
            acc_d  = {W_ZERO, mag_a_s};
          end else begin
            opnd_d = mag_a_s;
            acc_d  = {W_ZERO, mag_b_s};
          end
        end else begin
          if (mthi) hi_d = busA;
          else      hi_d = hi_q;
          if (mtlo) lo_d = busA;
          else      lo_d = lo_q;
        end
      end
      S_RUN: begin
        acc_d   = is_div_q ? div_step_s : mul_step_s;
        count_d = count_q + CNT_ONE;
        if (count_q == CNT_LAST) state_d = S_SIGN;
        else                     state_d = S_RUN;
      end
      S_SIGN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (is_div_q) begin
          // Divide by zero reports all-ones quotient and the raw dividend, bypassing sign fix.
          if (opnd_q == W_ZERO) begin
            hi_d = dvd_q;
            lo_d = W_ONES;
          end else begin
            hi_d = rem_fix_s;
            lo_d = quo_fix_s;
          end
        end else begin
          hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
          lo_d = prod_fix_s[WIDTH-1:0];
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = CNT_ZERO;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q   <= S_IDLE;
      count_q   <= CNT_ZERO;
      is_div_q  <= 1'b0;
      opnd_q    <= W_ZERO;
      acc_q     <= D_ZERO;
      dvd_q     <= W_ZERO;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= W_ZERO;
      lo_q      <= W_ZERO;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      is_div_q  <= is_div_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      dvd_q     <= dvd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: expected HI/LO pushed to a queue at issue, popped on done.
module tb_muldiv_unit;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] busA = 32'd0;
  logic [31:0] busB = 32'd0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] sb[$];

  always #5 CLK = ~CLK;

  muldiv_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .RSTn(RSTn), .start(start), .op(op), .busA(busA), .busB(busB),
    .mthi(mthi), .mtlo(mtlo), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference result {hi, lo} computed with native 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic signed [31:0] sa, sbv, q, r;
    logic [63:0] res;
    sa = a;
    sbv = b;
    case (o)
      2'd0: res = {32'd0, a} * {32'd0, b};
      2'd1: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        res = sp;
      end
      2'd2: begin
        if (b == 32'd0) res = {a, 32'hFFFFFFFF};
        else            res = {a % b, a / b};
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) res = {32'h00000000, 32'h80000000};
        else begin
          q = sa / sbv;
          r = sa % sbv;
          res = {r, q};
        end
      end
    endcase
    return res;
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] e);
    start = 1'b1;
    op = o;
    busA = a;
    busB = b;
    sb.push_back(e);
    step();
    start = 1'b0;
    busA = $urandom;
    busB = $urandom;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    check("done_low_after_start", {63'd0, done}, 64'd0);
  endtask

  // Waits for done (bounded); 'elapsed' is edges already taken since E0.
  task automatic wait_done(input string tag, input int elapsed);
    int n;
    bit got;
    logic [31:0] h0, l0;
    logic [63:0] e;
    h0 = hi;
    l0 = lo;
    n = elapsed;
    got = 1'b0;
    while (!got && n < 45) begin
      step();
      n++;
      if (done) got = 1'b1;
      else if (n == 32) check({tag, "_hilo_stable"}, {hi, lo}, {h0, l0});
      else got = 1'b0;
    end
    check({tag, "_done_seen"}, {63'd0, got}, 64'd1);
    if (got) begin
      check({tag, "_latency"}, 64'(n), 64'd33);
      check({tag, "_busy_clear"}, {63'd0, busy}, 64'd0);
      check({tag, "_sb_nonempty"}, {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({tag, "_hilo"}, {hi, lo}, e);
      end
    end
  endtask

  initial begin
    int ndone;
    logic [31:0] ra, rb;

    // Reset
    RSTn = 1'b0;
    step();
    step();
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    RSTn = 1'b1;

    // MTHI / MTLO in IDLE
    mthi = 1'b1;
    busA = 32'h12345678;
    step();
    mthi = 1'b0;
    check("mthi_hi", {32'd0, hi}, 64'h12345678);
    check("mthi_lo", {32'd0, lo}, 64'd0);
    check("mthi_no_done", {63'd0, done}, 64'd0);
    mtlo = 1'b1;
    busA = 32'hCAFEF00D;
    step();
    mtlo = 1'b0;
    check("mtlo_lo", {32'd0, lo}, 64'hCAFEF00D);

    // start with mtlo: start wins, LO untouched until SIGN
    mtlo = 1'b1;
    issue(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001});
    mtlo = 1'b0;
    check("start_wins_lo", {32'd0, lo}, 64'hCAFEF00D);
    wait_done("multu_max", 0);

    issue(2'd1, 32'hFFFFFFFD, 32'd7, {32'hFFFFFFFF, 32'hFFFFFFEB});
    wait_done("mult_neg", 0);
    issue(2'd2, 32'd100, 32'd7, {32'd2, 32'd14});
    wait_done("divu_100_7", 0);
    issue(2'd3, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD});
    wait_done("div_m7_2", 0);
    issue(2'd3, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD});
    wait_done("div_7_m2", 0);
    issue(2'd2, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF});
    wait_done("divu_by0", 0);
    issue(2'd3, 32'hFFFFFFFB, 32'd0, {32'hFFFFFFFB, 32'hFFFFFFFF});
    wait_done("div_by0", 0);
    issue(2'd3, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000});
    wait_done("div_ovf", 0);

    // Ignored inputs while running: start, operand changes, mthi/mtlo
    issue(2'd0, 32'd3, 32'd4, {32'd0, 32'd12});
    repeat (9) step();
    start = 1'b1;
    op = 2'd2;
    busA = 32'd9;
    busB = 32'd3;
    mtlo = 1'b1;
    mthi = 1'b1;
    step();
    start = 1'b0;
    mtlo = 1'b0;
    mthi = 1'b0;
    busA = 32'hDEADBEEF;
    busB = 32'h0BADF00D;
    wait_done("ignored_run", 10);
    // Back-to-back start at E34
    issue(2'd1, 32'hFFFFFFFD, 32'd7, model(2'd1, 32'hFFFFFFFD, 32'd7));
    wait_done("back_to_back", 0);

    // Reset in the middle of a DIV
    start = 1'b1;
    op = 2'd3;
    busA = 32'hFFFFFF9C;
    busB = 32'd7;
    step();
    start = 1'b0;
    repeat (14) step();
    RSTn = 1'b0;
    step();
    RSTn = 1'b1;
    check("midrst_hi", {32'd0, hi}, 64'd0);
    check("midrst_lo", {32'd0, lo}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) ndone++;
      step();
    end
    check("midrst_no_done", 64'(ndone), 64'd0);
    issue(2'd0, 32'd2, 32'd3, {32'd0, 32'd6});
    wait_done("after_rst_multu", 0);

    // Mixed operands against the reference model
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i >= 4) ? 32'($urandom_range(0, 15)) - 32'd8 : $urandom;
      issue(2'(i), ra, rb, model(2'(i), ra, rb));
      wait_done("mixed", 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
